// File: rtl/int_ctrl_if.sv
// CSR-file side of the interrupt controller.
// The controller reads the current CSR values and drives the write port.
interface int_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] csr_mie;
  logic [DATA_W-1:0] csr_mtvec;
  logic [DATA_W-1:0] csr_mepc;
  logic [DATA_W-1:0] csr_mstatus;
  logic [1:0]        privilege_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              wr_privilege_en_o;
  logic [1:0]        wr_privilege_o;

  modport master (
    input  csr_mie, csr_mtvec, csr_mepc, csr_mstatus, privilege_i,
    output wr_en_o, wr_addr_o, wr_data_o, wr_privilege_en_o, wr_privilege_o
  );

  modport slave (
    output csr_mie, csr_mtvec, csr_mepc, csr_mstatus, privilege_i,
    input  wr_en_o, wr_addr_o, wr_data_o, wr_privilege_en_o, wr_privilege_o
  );
endinterface

// File: rtl/int_ctrl.sv
// Core-local interrupt controller: latches and prioritises async sources, takes ecall/ebreak/mret,
// and sequences the mepc/mstatus/mcause writes before redirecting the pipeline.
module int_ctrl #(
  parameter int                 NUM_IRQ    = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK  = {NUM_IRQ{1'b0}},
  parameter int                 CAUSE_BASE = 16,
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ins_i,
  input  logic [ADDR_W-1:0]  ins_addr_i,
  input  logic               jump_flag_i,
  input  logic [ADDR_W-1:0]  jump_addr_i,
  input  logic               div_req_i,
  input  logic               div_busy_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  int_ctrl_if.master         csr,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               busy_o,
  output logic               int_assert_o,
  output logic [ADDR_W-1:0]  int_addr_o
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INS_MRET   = 32'h3020_0073;

  localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(12'h341);
  localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(12'h342);

  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_ENTER, S_MRET, S_ENTER_RET
  } state_e;

  // DIV, DIVU, REM, REMU: OP opcode, MULDIV funct7, funct3[2] set.
  function automatic logic is_div(input logic [31:0] ins);
    return (ins[6:0] == 7'b0110011) && (ins[31:25] == 7'b0000001) && ins[14];
  endfunction

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  pend_q, pend_d;
  logic [NUM_IRQ-1:0]  irq_prev_q, irq_prev_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                async_q, async_d;
  logic [DATA_W-1:0]   cause_q, cause_d;
  logic [ADDR_W-1:0]   mepc_q, mepc_d;
  logic [ADDR_W-1:0]   div_addr_q, div_addr_d;

  logic [NUM_IRQ-1:0]  pend_vec;
  logic [NUM_IRQ-1:0]  eligible;
  logic [IDX_W-1:0]    win_idx;
  logic                win_vld;
  logic                sync_req;
  logic [ADDR_W-1:0]   mtvec_base;
  logic                unused_mie;

  assign unused_mie = ^csr.csr_mie;

  // Level sources follow the line directly; edge sources come from the latched pend bits.
  always_comb begin
    pend_vec = (pend_q & EDGE_MASK) | (irq_i & ~EDGE_MASK);
    eligible = pend_vec & csr.csr_mie[CAUSE_BASE +: NUM_IRQ] & {NUM_IRQ{csr.csr_mstatus[3]}};
    win_idx  = '0;
    win_vld  = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    irq_prev_d = irq_i;
    pend_d     = ((pend_q & ~irq_ack_o) | (irq_i & ~irq_prev_q)) & EDGE_MASK;
    div_addr_d = (div_req_i && is_div(ins_i)) ? ins_addr_i : div_addr_q;
    sync_req   = ((ins_i == INS_ECALL) || (ins_i == INS_EBREAK)) && !div_req_i && !jump_flag_i;
    mtvec_base = ADDR_W'(csr.csr_mtvec) & ~ADDR_W'(3);
  end

  always_comb begin
    state_d                = state_q;
    idx_d                  = idx_q;
    async_d                = async_q;
    cause_d                = cause_q;
    mepc_d                 = mepc_q;
    busy_o                 = 1'b0;
    irq_ack_o              = '0;
    int_assert_o           = 1'b0;
    int_addr_o             = '0;
    csr.wr_en_o            = 1'b0;
    csr.wr_addr_o          = '0;
    csr.wr_data_o          = '0;
    csr.wr_privilege_en_o  = 1'b0;
    csr.wr_privilege_o     = 2'b11;
    if (rst) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sync_req) begin
            busy_o  = 1'b1;
            state_d = S_MEPC;
            async_d = 1'b0;
            cause_d = (ins_i == INS_ECALL) ? DATA_W'(11) : DATA_W'(3);
            mepc_d  = ins_addr_i;
          end else if (win_vld) begin
            busy_o  = 1'b1;
            state_d = S_MEPC;
            async_d = 1'b1;
            idx_d   = win_idx;
            cause_d = (DATA_W'(1) << (DATA_W - 1)) | (DATA_W'(CAUSE_BASE) + DATA_W'(win_idx));
            // An interrupted divide is replayed from its own address after return.
            if (div_req_i || div_busy_i) mepc_d = div_addr_d;
            else if (jump_flag_i)        mepc_d = jump_addr_i;
            else                         mepc_d = ins_addr_i;
          end else if (ins_i == INS_MRET) begin
            busy_o  = 1'b1;
            state_d = S_MRET;
          end
        end
        S_MEPC: begin
          busy_o        = 1'b1;
          csr.wr_en_o   = 1'b1;
          csr.wr_addr_o = A_MEPC;
          csr.wr_data_o = DATA_W'(mepc_q);
          irq_ack_o     = async_q ? (NUM_IRQ'(1) << idx_q) : '0;
          state_d       = S_MSTATUS;
        end
        S_MSTATUS: begin
          busy_o                 = 1'b1;
          csr.wr_en_o            = 1'b1;
          csr.wr_addr_o          = A_MSTATUS;
          csr.wr_data_o          = csr.csr_mstatus;
          csr.wr_data_o[12:11]   = csr.privilege_i;
          csr.wr_data_o[7]       = csr.csr_mstatus[3];
          csr.wr_data_o[3]       = 1'b0;
          csr.wr_privilege_en_o  = 1'b1;
          csr.wr_privilege_o     = 2'b11;
          state_d                = S_MCAUSE;
        end
        S_MCAUSE: begin
          busy_o        = 1'b1;
          csr.wr_en_o   = 1'b1;
          csr.wr_addr_o = A_MCAUSE;
          csr.wr_data_o = cause_q;
          state_d       = S_ENTER;
        end
        S_ENTER: begin
          busy_o       = 1'b1;
          int_assert_o = 1'b1;
          if (async_q && (csr.csr_mtvec[1:0] == 2'b01))
            int_addr_o = mtvec_base + ADDR_W'({cause_q[4:0], 2'b00});
          else
            int_addr_o = mtvec_base;
          state_d      = S_IDLE;
        end
        S_MRET: begin
          busy_o                 = 1'b1;
          csr.wr_en_o            = 1'b1;
          csr.wr_addr_o          = A_MSTATUS;
          csr.wr_data_o          = csr.csr_mstatus;
          csr.wr_data_o[3]       = csr.csr_mstatus[7];
          csr.wr_data_o[7]       = 1'b1;
          csr.wr_data_o[12:11]   = 2'b00;
          csr.wr_privilege_en_o  = 1'b1;
          csr.wr_privilege_o     = csr.csr_mstatus[12:11];
          state_d                = S_ENTER_RET;
        end
        S_ENTER_RET: begin
          busy_o       = 1'b1;
          int_assert_o = 1'b1;
          int_addr_o   = ADDR_W'(csr.csr_mepc);
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
    irq_prev_q <= irq_prev_d;
    idx_q      <= idx_d;
    async_q    <= async_d;
    cause_q    <= cause_d;
    mepc_q     <= mepc_d;
    div_addr_q <= div_addr_d;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a phase-based reference model that also plays the CSR file.
module tb_int_ctrl;
  localparam int NUM_IRQ    = 4;
  localparam int CAUSE_BASE = 16;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam logic [NUM_IRQ-1:0] EDGE_MASK = 4'b0101;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] DIV    = 32'h02c5_c533;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        ins_i;
  logic [ADDR_W-1:0]  ins_addr_i;
  logic               jump_flag_i;
  logic [ADDR_W-1:0]  jump_addr_i;
  logic               div_req_i;
  logic               div_busy_i;
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_ack_o;
  logic               busy_o;
  logic               int_assert_o;
  logic [ADDR_W-1:0]  int_addr_o;

  always #5 clk = ~clk;

  int_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cif ();

  int_ctrl #(
    .NUM_IRQ(NUM_IRQ), .EDGE_MASK(EDGE_MASK), .CAUSE_BASE(CAUSE_BASE),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst), .ins_i(ins_i), .ins_addr_i(ins_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .div_req_i(div_req_i), .div_busy_i(div_busy_i), .irq_i(irq_i),
    .csr(cif), .irq_ack_o(irq_ack_o), .busy_o(busy_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Environment CSR file, driven from the model's own expected writes.
  logic [31:0] e_mie, e_mtvec, e_mepc, e_mstatus, e_mcause;
  logic [1:0]  e_priv;

  // Reference model: phase counts cycles since acceptance; kind 1=exception, 2=interrupt, 3=mret.
  int                 m_ph, m_kind, m_idx;
  logic [31:0]        m_cause, m_mepc, m_div;
  logic [NUM_IRQ-1:0] m_pend, m_prev;
  int                 a_kind, a_idx;
  logic [31:0]        a_cause, a_mepc;

  logic               x_busy, x_wen, x_pen, x_ia;
  logic [31:0]        x_waddr, x_wdata, x_iaddr;
  logic [1:0]         x_priv;
  logic [NUM_IRQ-1:0] x_ack;

  logic [31:0] q_wa[$], q_wd[$], q_ia[$], q_ack[$], q_pv[$];

  function automatic logic [31:0] lg(input int which, input int i);
    case (which)
      0: if (i < q_wa.size())  return q_wa[i];
      1: if (i < q_wd.size())  return q_wd[i];
      2: if (i < q_ia.size())  return q_ia[i];
      3: if (i < q_ack.size()) return q_ack[i];
      default: if (i < q_pv.size()) return q_pv[i];
    endcase
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    q_wa.delete(); q_wd.delete(); q_ia.delete(); q_ack.delete(); q_pv.delete();
  endtask

  task automatic predict();
    logic [NUM_IRQ-1:0] elig;
    x_busy = 0; x_wen = 0; x_pen = 0; x_ia = 0;
    x_waddr = 0; x_wdata = 0; x_iaddr = 0; x_priv = 2'b11; x_ack = '0;
    a_kind = 0; a_idx = 0; a_cause = 0; a_mepc = 0;
    if (rst) return;
    if (m_ph == 0) begin
      for (int i = 0; i < NUM_IRQ; i++)
        elig[i] = (EDGE_MASK[i] ? m_pend[i] : irq_i[i]) & e_mie[CAUSE_BASE + i] & e_mstatus[3];
      if ((ins_i == ECALL || ins_i == EBREAK) && !div_req_i && !jump_flag_i) begin
        a_kind = 1; a_cause = (ins_i == ECALL) ? 32'd11 : 32'd3; a_mepc = ins_addr_i;
      end else if (elig != 0) begin
        a_kind = 2;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (elig[i]) a_idx = i;
        a_cause = 32'h8000_0000 + CAUSE_BASE + a_idx;
        if (div_req_i || div_busy_i) a_mepc = (div_req_i && ins_i == DIV) ? ins_addr_i : m_div;
        else if (jump_flag_i)        a_mepc = jump_addr_i;
        else                         a_mepc = ins_addr_i;
      end else if (ins_i == MRET) begin
        a_kind = 3;
      end
      x_busy = (a_kind != 0);
    end else if (m_kind == 3) begin
      x_busy = 1;
      if (m_ph == 1) begin
        x_wen = 1; x_waddr = 32'h300; x_pen = 1; x_priv = e_mstatus[12:11];
        x_wdata = (e_mstatus & ~32'h1888) | (32'(e_mstatus[7]) << 3) | 32'h80;
      end else begin
        x_ia = 1; x_iaddr = e_mepc;
      end
    end else begin
      x_busy = 1;
      case (m_ph)
        1: begin
          x_wen = 1; x_waddr = 32'h341; x_wdata = m_mepc;
          if (m_kind == 2) x_ack = NUM_IRQ'(1 << m_idx);
        end
        2: begin
          x_wen = 1; x_waddr = 32'h300; x_pen = 1; x_priv = 2'b11;
          x_wdata = (e_mstatus & ~32'h1888) | (32'(e_priv) << 11) | (32'(e_mstatus[3]) << 7);
        end
        3: begin x_wen = 1; x_waddr = 32'h342; x_wdata = m_cause; end
        default: begin
          x_ia = 1;
          x_iaddr = (m_kind == 2 && e_mtvec[1:0] == 2'b01) ?
                    (e_mtvec & ~32'h3) + 32'(m_cause[4:0]) * 4 : (e_mtvec & ~32'h3);
        end
      endcase
    end
  endtask

  task automatic update();
    if (div_req_i && ins_i == DIV) m_div = ins_addr_i;
    if (rst) begin
      m_ph = 0; m_kind = 0; m_pend = '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++)
        if (EDGE_MASK[i]) begin
          if (irq_i[i] && !m_prev[i]) m_pend[i] = 1'b1;
          else if (x_ack[i])          m_pend[i] = 1'b0;
        end
      if (x_wen) begin
        if (x_waddr == 32'h341) e_mepc    = x_wdata;
        if (x_waddr == 32'h300) e_mstatus = x_wdata;
        if (x_waddr == 32'h342) e_mcause  = x_wdata;
      end
      if (x_pen) e_priv = x_priv;
      if (m_ph == 0) begin
        if (a_kind != 0) begin
          m_kind = a_kind; m_idx = a_idx; m_cause = a_cause; m_mepc = a_mepc; m_ph = 1;
        end
      end else if (m_ph == 4 || (m_kind == 3 && m_ph == 2)) begin
        m_ph = 0; m_kind = 0;
      end else begin
        m_ph++;
      end
    end
    m_prev = irq_i;
  endtask

  task automatic step();
    @(negedge clk);
    cif.csr_mie = e_mie; cif.csr_mtvec = e_mtvec; cif.csr_mepc = e_mepc;
    cif.csr_mstatus = e_mstatus; cif.privilege_i = e_priv;
    #1;
    predict();
    chk("busy", 64'(busy_o), 64'(x_busy));
    chk("wr_en", 64'(cif.wr_en_o), 64'(x_wen));
    if (x_wen || rst) begin
      chk("wr_addr", 64'(cif.wr_addr_o), 64'(x_waddr));
      chk("wr_data", 64'(cif.wr_data_o), 64'(x_wdata));
    end
    chk("priv_en", 64'(cif.wr_privilege_en_o), 64'(x_pen));
    chk("priv", 64'(cif.wr_privilege_o), 64'(x_priv));
    chk("irq_ack", 64'(irq_ack_o), 64'(x_ack));
    chk("int_assert", 64'(int_assert_o), 64'(x_ia));
    if (x_ia || rst) chk("int_addr", 64'(int_addr_o), 64'(x_iaddr));
    if (cif.wr_en_o) begin q_wa.push_back(cif.wr_addr_o); q_wd.push_back(cif.wr_data_o); end
    if (cif.wr_privilege_en_o) q_pv.push_back(32'(cif.wr_privilege_o));
    if (int_assert_o) q_ia.push_back(int_addr_o);
    if (irq_ack_o != 0) q_ack.push_back(32'(irq_ack_o));
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1; ins_i = NOP; ins_addr_i = 32'h100; jump_flag_i = 0; jump_addr_i = 0;
    div_req_i = 0; div_busy_i = 0; irq_i = '0;
    e_mie = 0; e_mtvec = 32'h800; e_mepc = 0; e_mstatus = 0; e_mcause = 0; e_priv = 2'b11;
    m_ph = 0; m_kind = 0; m_idx = 0; m_cause = 0; m_mepc = 0; m_div = 0;
    m_pend = '0; m_prev = '0;
    steps(3);
    rst = 0;

    // Edge source 2 at ins_addr 0x100, direct mtvec.
    e_mie = 32'h0004_0000; e_mstatus = 32'h8; clear_logs();
    irq_i[2] = 1'b1;
    steps(7);
    irq_i[2] = 1'b0;
    chk("a_nwrites", 64'(q_wa.size()), 64'd3);
    chk("a_mepc_addr", 64'(lg(0, 0)), 64'h341);
    chk("a_mepc", 64'(lg(1, 0)), 64'h100);
    chk("a_mstatus", 64'(lg(1, 1)), 64'h1880);
    chk("a_mcause_addr", 64'(lg(0, 2)), 64'h342);
    chk("a_mcause", 64'(lg(1, 2)), 64'h8000_0012);
    chk("a_ack", 64'(lg(3, 0)), 64'h4);
    chk("a_target", 64'(lg(2, 0)), 64'h800);

    // mret with MPIE=1, MPP=0.
    e_mstatus = 32'h80; e_mepc = 32'h104; clear_logs();
    ins_i = MRET; step(); ins_i = NOP; steps(3);
    chk("r_mstatus", 64'(lg(1, 0)), 64'h88);
    chk("r_priv", 64'(lg(4, 0)), 64'h0);
    chk("r_target", 64'(lg(2, 0)), 64'h104);

    // Level sources 1 and 3 together, vectored mtvec; 3 follows after mret.
    e_mie = 32'h000F_0000; e_mtvec = 32'h1001; clear_logs();
    irq_i = 4'b1010;
    steps(5);
    irq_i[1] = 1'b0;
    step();
    ins_i = MRET; step(); ins_i = NOP; steps(7);
    irq_i = '0;
    chk("b_ack1", 64'(lg(3, 0)), 64'h2);
    chk("b_cause1", 64'(lg(1, 2)), 64'h8000_0011);
    chk("b_vec1", 64'(lg(2, 0)), 64'h1044);
    chk("b_ack3", 64'(lg(3, 1)), 64'h8);
    chk("b_cause3", 64'(lg(1, 6)), 64'h8000_0013);
    chk("b_vec3", 64'(lg(2, 2)), 64'h104C);

    // ecall held off by a jump, taken the next cycle.
    ins_addr_i = 32'h300; clear_logs();
    ins_i = ECALL; jump_flag_i = 1; jump_addr_i = 32'h480; step();
    chk("c_deferred", 64'(q_wa.size()), 64'd0);
    jump_flag_i = 0; step(); ins_i = NOP; steps(4);
    chk("c_mepc", 64'(lg(1, 0)), 64'h300);
    chk("c_cause", 64'(lg(1, 2)), 64'd11);
    chk("c_target", 64'(lg(2, 0)), 64'h1000);

    // Interrupt while a divide started at 0x200 is still busy.
    e_mstatus = e_mstatus | 32'h8; e_mtvec = 32'h800; clear_logs();
    ins_i = DIV; ins_addr_i = 32'h200; div_req_i = 1; step();
    ins_i = NOP; ins_addr_i = 32'h204; div_req_i = 0; div_busy_i = 1; irq_i[0] = 1'b1;
    steps(6);
    div_busy_i = 0; irq_i[0] = 1'b0;
    chk("d_mepc", 64'(lg(1, 0)), 64'h200);
    chk("d_cause", 64'(lg(1, 2)), 64'h8000_0010);

    // Pending edge blocked by MIE=0, taken once MIE is set.
    e_mstatus = e_mstatus & ~32'h8; clear_logs();
    irq_i[2] = 1'b1; steps(4);
    chk("e_masked", 64'(q_wa.size()), 64'd0);
    e_mstatus = e_mstatus | 32'h8; steps(5);
    chk("e_cause", 64'(lg(1, 2)), 64'h8000_0012);

    // Reset in the mstatus cycle aborts the sequence.
    irq_i[2] = 1'b0; step();
    e_mstatus = e_mstatus | 32'h8; clear_logs();
    irq_i[2] = 1'b1; steps(3);
    rst = 1; step(); rst = 0; irq_i = '0; steps(3);
    chk("f_nwrites", 64'(q_wa.size()), 64'd1);
    chk("f_npriv", 64'(q_pv.size()), 64'd0);
    chk("f_nassert", 64'(q_ia.size()), 64'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) irq_i = irq_i ^ NUM_IRQ'(1 << $urandom_range(0, NUM_IRQ - 1));
      ins_addr_i = ins_addr_i + 32'd4;
      div_req_i  = 0;
      if (r < 8)       ins_i = ECALL;
      else if (r < 13) ins_i = EBREAK;
      else if (r < 20) ins_i = MRET;
      else if (r < 30) begin ins_i = DIV; div_req_i = 1; end
      else             ins_i = NOP;
      jump_flag_i = ($urandom_range(0, 3) == 0);
      jump_addr_i = $urandom & ~32'h3;
      div_busy_i  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 40) == 0) e_mstatus = e_mstatus ^ 32'h8;
      if ($urandom_range(0, 60) == 0) e_mie = $urandom & 32'h000F_0000;
      if ($urandom_range(0, 80) == 0) e_mtvec = ($urandom & 32'h0000_FFF0) | 32'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
